button_gesture: RTL and testbench



---
 rtl/button_gesture.sv | 145 ++++++++++++++
 tb/tb_button_gesture.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/button_gesture.sv
// button_gesture
//   Classifies a debounced button level into short press, long press and
//   double press gestures, each reported as a registered one-cycle pulse.
//
//   Parameters
//     LONG_CYCLES  consecutive high samples that make a long press (>= 2)
//     GAP_CYCLES   consecutive low samples after a short press that confirm
//                  a single click (>= 2)
//
//   Ports
//     clk           system clock, rising edge
//     rst           synchronous, active-high reset
//     in            debounced button level, 1 = pressed, synchronous to clk
//     short_press   one-cycle pulse: single short click completed
//     long_press    one-cycle pulse: button held for LONG_CYCLES samples
//     double_press  one-cycle pulse: second press began within the gap window

module button_gesture #(
    parameter int unsigned LONG_CYCLES = 12_000_000,
    parameter int unsigned GAP_CYCLES  = 3_600_000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic short_press,
    output logic long_press,
    output logic double_press
);

    localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    // Count values at which the final qualifying sample is being taken.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StWaitRel = 2'd0,
        StIdle    = 2'd1,
        StDown1   = 2'd2,
        StGap     = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;

    // Saturating increment so the counter can never wrap inside a state.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // State register, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StWaitRel;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end

    // Next-state and counter logic. The counter is reloaded on every
    // transition; entering DOWN1/GAP loads 1 because the sample that caused
    // the transition already counts toward the new run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StWaitRel: begin
                cnt_d = '0;
                if (!in) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                cnt_d = '0;
                if (in) begin
                    state_d = StDown1;
                    cnt_d   = CNT_ONE;
                end
            end
            StDown1: begin
                if (in) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = StWaitRel;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = StGap;
                    cnt_d   = CNT_ONE;
                end
            end
            StGap: begin
                if (in) begin
                    // Second press: wait for its release, never classify as long.
                    state_d = StWaitRel;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StWaitRel;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode; results are registered so each pulse lands one cycle
    // after the deciding sample and no path exists from in to the outputs.
    always_comb begin
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            StDown1: long_d = in && (cnt_q == LONG_LAST);
            StGap: begin
                double_d = in;
                short_d  = !in && (cnt_q == GAP_LAST);
            end
            default: ;
        endcase
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;

endmodule

// File: tb/tb_button_gesture.sv
module tb_button_gesture;

    localparam int unsigned LONG_CYCLES = 8;
    localparam int unsigned GAP_CYCLES  = 5;

    logic clk;
    logic rst;
    logic in;
    logic short_press;
    logic long_press;
    logic double_press;

    int total;
    int bad;

    button_gesture #(
        .LONG_CYCLES(LONG_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge: start of a new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs as {short, long, double}.
    function automatic logic [2:0] outs();
        return {short_press, long_press, double_press};
    endfunction

    task automatic test_reset();
        logic [2:0] exp;
        rst = 1'b1;
        in  = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (outs() !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000", outs());
        end
        rst = 1'b0;
        // Held through reset: nothing while held nor on release.
        for (int k = 0; k < 26; k++) begin
            in = (k < 20);
            total++;
            if (outs() !== 3'b000) begin
                bad++;
                $display("FAIL reset_held k=%0d: got %b want 000", k, outs());
            end
            tick();
        end
        // Fresh 3-cycle press afterwards is a normal short press at T0+8.
        for (int k = 0; k < 16; k++) begin
            in  = (k < 3);
            exp = (k == 8) ? 3'b100 : 3'b000;
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL reset_then_short k=%0d: got %b want %b", k, outs(), exp);
            end
            tick();
        end
    endtask

    task automatic test_short();
        logic [2:0] exp;
        for (int k = 0; k < 16; k++) begin
            in  = (k < 3);
            exp = (k == 8) ? 3'b100 : 3'b000;
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL short k=%0d: got %b want %b", k, outs(), exp);
            end
            tick();
        end
    endtask

    task automatic test_long();
        logic [2:0] exp;
        for (int k = 0; k < 55; k++) begin
            in  = (k < 40);
            exp = (k == 8) ? 3'b010 : 3'b000;
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL long k=%0d: got %b want %b", k, outs(), exp);
            end
            tick();
        end
    endtask

    task automatic test_long_minus_one();
        logic [2:0] exp;
        for (int k = 0; k < 20; k++) begin
            in  = (k < 7);
            exp = (k == 12) ? 3'b100 : 3'b000;
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL long_minus_one k=%0d: got %b want %b", k, outs(), exp);
            end
            tick();
        end
    endtask

    task automatic test_double();
        logic [2:0] exp;
        // High k=0..1, R=2, low 2..5, P=6 held 30 cycles, double at R+5=7.
        for (int k = 0; k < 50; k++) begin
            in  = (k < 2) || (k >= 6 && k < 36);
            exp = (k == 7) ? 3'b001 : 3'b000;
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL double k=%0d: got %b want %b", k, outs(), exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_in_gap();
        logic [2:0] exp;
        // High k=0..3, reset during k=5 while in GAP: gesture discarded.
        for (int k = 0; k < 20; k++) begin
            in  = (k < 4);
            rst = (k == 5);
            total++;
            if (outs() !== 3'b000) begin
                bad++;
                $display("FAIL reset_in_gap k=%0d: got %b want 000", k, outs());
            end
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            in  = (k < 2);
            exp = (k == 7) ? 3'b100 : 3'b000;
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL after_reset_short k=%0d: got %b want %b", k, outs(), exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        // Short press ends at k=8 (R=3); a press sampled at k=8 is a fresh T0.
        for (int k = 0; k < 26; k++) begin
            in = (k < 3) || (k >= 8 && k < 11);
            if (k == 8 || k == 16) exp = 3'b100;
            else exp = 3'b000;
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL back_to_back k=%0d: got %b want %b", k, outs(), exp);
            end
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        in    = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_long_minus_one();
        test_double();
        test_reset_in_gap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
